// File: rtl/phase_accum.sv
// Phase accumulator with clipped signed frequency word and one-cycle I/Q pass-through.
// The phase code spans [-OPI, OPI]; OPI stands for pi and DPI = 2*OPI for a full turn.
module phase_accum #(
    parameter int OPI = 1608
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        freq_load,
    input  logic [15:0] freq_word,
    input  logic        ivalid,
    input  logic        sof,
    input  logic [15:0] in_i,
    input  logic [15:0] in_q,
    output logic        ovalid,
    output logic [15:0] out_i,
    output logic [15:0] out_q,
    output logic [15:0] phase,
    output logic        freq_sat
);

    localparam logic signed [17:0] OPI_S = 18'(OPI);
    localparam logic signed [17:0] DPI_S = 18'(2 * OPI);

    logic signed [15:0] inc_q, inc_d;
    logic signed [15:0] acc_q, acc_d;
    logic               sat_q, sat_d;
    logic               ovalid_q, ovalid_d;
    logic        [15:0] out_i_q, out_i_d;
    logic        [15:0] out_q_q, out_q_d;
    logic        [15:0] phase_q, phase_d;

    logic signed [17:0] fw_ext;
    logic signed [17:0] base;
    logic signed [17:0] sum;
    logic signed [17:0] wrapped;

    always_comb begin
        fw_ext  = {{2{freq_word[15]}}, freq_word};
        base    = sof ? 18'sd0 : {{2{acc_q[15]}}, acc_q};
        sum     = base + {{2{inc_q[15]}}, inc_q};
        wrapped = sum;
        if (sum > OPI_S) begin
            wrapped = sum - DPI_S;
        end else if (sum < -OPI_S) begin
            wrapped = sum + DPI_S;
        end
    end

    always_comb begin
        inc_d    = inc_q;
        sat_d    = sat_q;
        acc_d    = acc_q;
        ovalid_d = ivalid;
        out_i_d  = out_i_q;
        out_q_d  = out_q_q;
        phase_d  = phase_q;

        // The sample in this cycle still advances with the old increment.
        if (freq_load) begin
            if (fw_ext > OPI_S) begin
                inc_d = OPI_S[15:0];
                sat_d = 1'b1;
            end else if (fw_ext < -OPI_S) begin
                inc_d = 16'(-OPI_S);
                sat_d = 1'b1;
            end else begin
                inc_d = freq_word;
                sat_d = 1'b0;
            end
        end

        if (ivalid) begin
            phase_d = base[15:0];
            acc_d   = wrapped[15:0];
            out_i_d = in_i;
            out_q_d = in_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inc_q    <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            ovalid_q <= 1'b0;
            out_i_q  <= '0;
            out_q_q  <= '0;
            phase_q  <= '0;
        end else begin
            inc_q    <= inc_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            ovalid_q <= ovalid_d;
            out_i_q  <= out_i_d;
            out_q_q  <= out_q_d;
            phase_q  <= phase_d;
        end
    end

    assign ovalid   = ovalid_q;
    assign out_i    = out_i_q;
    assign out_q    = out_q_q;
    assign phase    = phase_q;
    assign freq_sat = sat_q;

endmodule

// File: tb/tb_phase_accum.sv
// Scenario bench for phase_accum: expected samples queued at drive time,
// popped and compared when the registered output appears.
module tb_phase_accum;

    typedef struct {
        logic [15:0] ph;
        logic [15:0] i;
        logic [15:0] q;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        freq_load;
    logic [15:0] freq_word;
    logic        ivalid;
    logic        sof;
    logic [15:0] in_i;
    logic [15:0] in_q;
    logic        ovalid;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic [15:0] phase;
    logic        freq_sat;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t last;

    phase_accum #(.OPI(1608)) dut (
        .clock(clock), .reset(reset),
        .freq_load(freq_load), .freq_word(freq_word),
        .ivalid(ivalid), .sof(sof),
        .in_i(in_i), .in_q(in_q),
        .ovalid(ovalid), .out_i(out_i), .out_q(out_q),
        .phase(phase), .freq_sat(freq_sat)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one sample (optionally with a same-cycle load), then check its output.
    task automatic samp(input logic s, input int ph,
                        input logic ld = 1'b0, input int w = 0);
        exp_t e;
        exp_t g;
        ivalid    = 1'b1;
        sof       = s;
        in_i      = 16'($urandom);
        in_q      = 16'($urandom);
        freq_load = ld;
        freq_word = 16'(w);
        e.ph = 16'(ph);
        e.i  = in_i;
        e.q  = in_q;
        sb.push_back(e);
        tick();
        ivalid    = 1'b0;
        sof       = 1'b0;
        freq_load = 1'b0;
        checks++;
        if (ovalid !== 1'b1) begin
            failures++;
            $display("FAIL ovalid got=%b exp=1", ovalid);
        end else begin
            g = sb.pop_front();
            last = g;
            checks++;
            if (phase !== g.ph || out_i !== g.i || out_q !== g.q) begin
                failures++;
                $display("FAIL sample got ph=%0d i=%h q=%h exp ph=%0d i=%h q=%h",
                         $signed(phase), out_i, out_q, $signed(g.ph), g.i, g.q);
            end
        end
    endtask

    task automatic load(input int w);
        freq_load = 1'b1;
        freq_word = 16'(w);
        tick();
        freq_load = 1'b0;
    endtask

    task automatic idle_check(input string nm);
        in_i = 16'($urandom);
        in_q = 16'($urandom);
        tick();
        checks++;
        if (ovalid !== 1'b0 || phase !== last.ph ||
            out_i !== last.i || out_q !== last.q) begin
            failures++;
            $display("FAIL %s got v=%b ph=%0d i=%h q=%h exp v=0 ph=%0d i=%h q=%h",
                     nm, ovalid, $signed(phase), out_i, out_q,
                     $signed(last.ph), last.i, last.q);
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (ovalid !== 1'b0 || out_i !== 16'h0 || out_q !== 16'h0 ||
            phase !== 16'h0 || freq_sat !== 1'b0) begin
            failures++;
            $display("FAIL %s got v=%b i=%h q=%h ph=%h sat=%b exp all 0",
                     nm, ovalid, out_i, out_q, phase, freq_sat);
        end
    endtask

    task automatic check_sat(input string nm, input logic exp);
        checks++;
        if (freq_sat !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, freq_sat, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; freq_load = 1'b1; freq_word = 16'd5000;
        ivalid = 1'b1; sof = 1'b1; in_i = 16'hAAAA; in_q = 16'h5555;
        tick();
        tick();
        check_zero("reset_state");
        reset = 1'b0; freq_load = 1'b0; ivalid = 1'b0; sof = 1'b0;
        tick();
        last.ph = 16'h0; last.i = 16'h0; last.q = 16'h0;
        samp(1'b0, 0);
        samp(1'b0, 0);
        samp(1'b0, 0);
    endtask

    task automatic test_pos_wrap();
        load(100);
        check_sat("sat_after_100", 1'b0);
        for (int k = 0; k < 18; k++)
            samp(k == 0, (k < 17) ? 100 * k : -1516);
    endtask

    task automatic test_neg_wrap();
        load(-1000);
        samp(1'b1, 0);
        samp(1'b0, -1000);
        samp(1'b0, 1216);
        samp(1'b0, 216);
        samp(1'b0, -784);
    endtask

    task automatic test_saturation();
        load(2000);
        check_sat("sat_pos", 1'b1);
        samp(1'b1, 0);
        samp(1'b0, 1608);
        samp(1'b0, 0);
        samp(1'b0, 1608);
        load(500);
        check_sat("sat_clear", 1'b0);
        load(-2000);
        check_sat("sat_neg", 1'b1);
        samp(1'b1, 0);
        samp(1'b0, -1608);
        samp(1'b0, 0);
        load(1608);
        check_sat("sat_edge", 1'b0);
    endtask

    task automatic test_gapped();
        load(300);
        samp(1'b1, 0);
        idle_check("gap0");
        idle_check("gap1");
        samp(1'b0, 300);
        samp(1'b0, 600);
    endtask

    task automatic test_back_to_back();
        load(100);
        samp(1'b1, 0);
        samp(1'b0, 100);
        samp(1'b0, 200, 1'b1, 50);
        samp(1'b0, 300);
        samp(1'b0, 350);
    endtask

    task automatic test_sof_reset();
        load(100);
        samp(1'b1, 0);
        for (int k = 1; k < 7; k++)
            samp(1'b0, 100 * k);
        samp(1'b1, 0);
        samp(1'b0, 100);
        samp(1'b0, 200);
        reset = 1'b1; ivalid = 1'b1; sof = 1'b0;
        freq_load = 1'b1; freq_word = 16'd77;
        tick();
        check_zero("midstream_reset");
        reset = 1'b0; ivalid = 1'b0; freq_load = 1'b0;
        samp(1'b0, 0);
        samp(1'b0, 0);
    endtask

    initial begin
        reset = 1'b1; freq_load = 1'b0; freq_word = '0;
        ivalid = 1'b0; sof = 1'b0; in_i = '0; in_q = '0;
        last.ph = '0; last.i = '0; last.q = '0;
        test_reset();
        test_pos_wrap();
        test_neg_wrap();
        test_saturation();
        test_gapped();
        test_back_to_back();
        test_sof_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_accum.md
PHASE_ACCUM -- requirements
Module: phase_accum

Interface
REQ-001 The block SHALL have parameter OPI, default 1608, meaning the phase code for pi; DPI = 2*OPI.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all logic on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port freq_load, input, 1 bit: load strobe for freq_word.
REQ-005 The block SHALL have port freq_word, input, 16 bits: signed two's-complement per-sample phase increment.
REQ-006 The block SHALL have port ivalid, input, 1 bit: input sample qualifier.
REQ-007 The block SHALL have port sof, input, 1 bit: start-of-frame, sampled only when ivalid=1.
REQ-008 The block SHALL have ports in_i and in_q, input, 16 bits each: sample I/Q, passed through.
REQ-009 The block SHALL have port ovalid, output, 1 bit: output sample qualifier.
REQ-010 The block SHALL have ports out_i and out_q, output, 16 bits each: delayed in_i/in_q.
REQ-011 The block SHALL have port phase, output, 16 bits: signed phase for the out_i/out_q sample, in the range [-OPI, OPI].
REQ-012 The block SHALL have port freq_sat, output, 1 bit: set when the last loaded freq_word was clipped.

Function
REQ-013 The block SHALL hold a 16-bit signed increment register inc and a 16-bit signed accumulator acc, where |acc| <= OPI at all times.
REQ-014 On freq_load=1, inc SHALL take clip(freq_word) at the next clock edge.
- clip(x) is +OPI when x > OPI, -OPI when x < -OPI, and x otherwise.
- freq_sat takes the value 1 if clipping occurred and 0 if not, and holds until the next freq_load.
REQ-015 With freq_load=1 and ivalid=1 in the same cycle, that cycle's acc update SHALL use the old inc; the new inc applies from the next ivalid onward.
REQ-016 Each ivalid=1 cycle SHALL produce exactly one output, registered, with ovalid=1 one clock later; latency is fixed at 1 cycle.
REQ-017 Each ivalid=0 cycle SHALL produce ovalid=0 one clock later.
REQ-018 While ovalid=0, out_i, out_q and phase SHALL hold their last values.
REQ-019 For ivalid=1 and sof=1, the output phase SHALL be 0, and acc SHALL become wrap(0 + inc).
REQ-020 For ivalid=1 and sof=0, the output phase SHALL equal the current acc, and acc SHALL become wrap(acc + inc).
REQ-021 wrap(s) SHALL be computed on at least 18-bit signed intermediates with exactly one correction step:
- s - DPI if s > OPI;
- s + DPI if s < -OPI;
- s otherwise.
REQ-022 A value exactly equal to +OPI or -OPI SHALL NOT be wrapped.
REQ-023 Between ivalid pulses, acc SHALL remain unchanged; gaps in ivalid SHALL NOT advance the phase.
REQ-024 out_i and out_q SHALL equal the in_i and in_q captured on the same ivalid cycle as the phase value.
REQ-025 When sof=1 arrives mid-stream, the block SHALL restart the phase at 0 with no bubble and no extra latency.
REQ-026 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-027 When reset=1 at a clock edge, ovalid, out_i, out_q, phase, freq_sat, inc and acc SHALL all become 0.
REQ-028 Reset SHALL take priority over freq_load, ivalid and sof in the same cycle.
REQ-029 After reset deasserts, the first ivalid SHALL output phase 0 regardless of sof, and the phase SHALL advance by 0 until a freq_load occurs.
REQ-030 A reset asserted mid-stream SHALL discard any in-flight output; ovalid SHALL be 0 in the cycle after the reset edge.

Verification
REQ-031 Scenario, positive wrap:
- stimulus: load 100, then 18 consecutive ivalid samples with sof on the first;
- required response: phases 0, 100, ..., 1600 for samples 0-16, then -1516 for sample 17.
REQ-032 Scenario, negative wrap:
- stimulus: load -1000, then 5 samples with sof on the first;
- required response: phases 0, -1000, 1216, 216, -784.
REQ-033 Scenario, saturation:
- stimulus: load 2000;
- required response: freq_sat=1, and phases 0, 1608, 0, 1608.
- follow-up stimulus: load 500;
- required response: freq_sat=0.
REQ-034 Scenario, gapped input and pass-through:
- stimulus: inc=300, ivalid pattern 1,0,0,1,1;
- required response: ovalid pattern 1,0,0,1,1 delayed by one cycle, phases 0, 300, 600, and out_i/out_q match the inputs.
REQ-035 Scenario, simultaneous load and sample:
- stimulus: inc=100 running at acc=200, then freq_load=1 with freq_word=50 plus ivalid in the same cycle;
- required response: that sample outputs phase 200, the next sample outputs 300, and the following one outputs 350.
REQ-036 Scenario, mid-stream sof and reset:
- stimulus: sof=1 during a stream at acc=700;
- required response: output phase 0.
- stimulus: reset=1 during a stream;
- required response: next-cycle ovalid=0 with all outputs 0, and after reset the first sample gives phase 0 with increment 0.
